pc_control_unit: RTL and testbench
==================================

Name: pc_control_unit

Overview:
Program-counter register for the fetch stage of the superscalar RISC-V core. Each cycle it selects the next fetch address: sequential (PC+4), JAL target from decode, or JALR/conditional-branch target from execute. The PC advances only when the instruction-memory read burst completes (rlast). Redirects that arrive while fetch is stalled are held and applied at the next advance.

Parameters:
XLEN, 32, width of addresses and PC.
RESET_ADDR, 32'h0000_0000, PC value after reset.
PC_STEP, 4, sequential increment in bytes.

Ports:
clk  input  1  rising-edge clock; all state updates on this edge.
rst_n  input  1  synchronous reset, active-high (asserted = 1 despite the suffix).
jal  input  1  JAL redirect request from decode, valid this cycle.
jalr_jcond  input  1  JALR/taken-conditional-branch redirect request from execute, valid this cycle.
jal_addr  input  XLEN  JAL target; sampled only when jal=1.
jalr_jcond_addr  input  XLEN  JALR/branch target; sampled only when jalr_jcond=1.
rlast  input  1  last beat of the current instruction fetch; 1 = fetch done, PC may advance.
pc_addr  output  XLEN  current fetch address, registered.

Behaviour:
- State: pc (XLEN), pend_valid (1), pend_kind (1: 1=jalr_jcond, 0=jal), pend_addr (XLEN).
- Reset (rst_n=1 at rising edge): pc=RESET_ADDR, pend_valid=0, pend_kind=0, pend_addr=0. Reset overrides all other inputs, including mid-redirect and mid-fetch; pending redirects are discarded.
- pc_addr is driven directly from the pc register; no combinational path from inputs to pc_addr.
- Advance cycle (rlast=1), next pc priority, highest first:
  1. jalr_jcond=1 -> jalr_jcond_addr
  2. pend_valid=1 and pend_kind=1 -> pend_addr
  3. jal=1 -> jal_addr
  4. pend_valid=1 and pend_kind=0 -> pend_addr
  5. otherwise -> pc+PC_STEP, modulo 2^XLEN (0xFFFF_FFFC wraps to 0x0000_0000)
  pend_valid is cleared on every advance cycle.
- Stall cycle (rlast=0): pc holds. A redirect is captured into pending storage:
  - jalr_jcond=1: pend_valid=1, pend_kind=1, pend_addr=jalr_jcond_addr. Overwrites any pending entry.
  - else jal=1 and not (pend_valid and pend_kind=1): pend_valid=1, pend_kind=0, pend_addr=jal_addr.
  - else: pending state unchanged.
- jalr_jcond beats jal when both are asserted in the same cycle. A held level (same request on consecutive advance cycles) reloads the same target each cycle. No pulse detection.
- Targets are not masked or alignment-checked; the value is loaded verbatim (e.g. 10).
- Latency: redirect presented in cycle N with rlast=1 appears on pc_addr after edge N (one cycle).
- X on jal_addr or jalr_jcond_addr while the matching request is 0 must not affect state.

Test Plan:
- Reset then sequential: rst_n=1 for 1 cycle, then rst_n=0, rlast=1, no redirects -> pc_addr 0, 4, 8, 12 on successive edges.
- JAL redirect: rlast=1, jal=1, jal_addr=10 held 2 cycles -> pc_addr=10, 10. Then jal=0 -> 14.
- Priority: jal=1/jal_addr=10 and jalr_jcond=1/jalr_jcond_addr=20 in the same cycle, rlast=1 -> pc_addr=20. With jalr_jcond held while rlast=1, pc_addr stays 20.
- Stall hold: pc_addr=20, rlast=0 for 5 cycles, no redirects -> pc_addr stays 20. rlast=1 -> 24.
- Pending redirect: rlast=0, jal=1/jal_addr=0x100 for 1 cycle, then jalr_jcond=1/addr=0x200 for 1 cycle; rlast=1 with no requests -> pc_addr=0x200. Next advance -> 0x204.
- Reset mid-operation: pending valid, pc=0x40, rst_n=1 -> pc_addr=0 next edge. After release with rlast=1 -> 4 (pending discarded). Also check wrap: pc=0xFFFF_FFFC, rlast=1 -> 0.

Source files
------------

// File: rtl/pc_control_unit.sv
// pc_control_unit
//   Fetch-stage program counter. Picks the next fetch address each time the
//   instruction-memory burst finishes (rlast). The three sources are the
//   sequential address (pc + PC_STEP), a JAL target from decode, and a
//   JALR / taken-branch target from execute. A redirect that arrives while
//   fetch is stalled is held in a one-entry pending slot and applied at the
//   next advance.
//
// Ports
//   clk              in   rising-edge clock
//   rst_n            in   synchronous reset, ACTIVE-HIGH (1 = reset) despite the name
//   jal              in   JAL redirect request from decode
//   jalr_jcond       in   JALR / taken-branch redirect request from execute
//   jal_addr         in   JAL target, only looked at when jal = 1
//   jalr_jcond_addr  in   JALR / branch target, only looked at when jalr_jcond = 1
//   rlast            in   last beat of the current fetch; the PC advances on this
//   pc_addr          out  current fetch address, straight from the PC register
module pc_control_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_ADDR = '0,
  parameter int              PC_STEP    = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            jal,
  input  logic            jalr_jcond,
  input  logic [XLEN-1:0] jal_addr,
  input  logic [XLEN-1:0] jalr_jcond_addr,
  input  logic            rlast,
  output logic [XLEN-1:0] pc_addr
);

  localparam logic KIND_JAL  = 1'b0;
  localparam logic KIND_JALR = 1'b1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic            pend_valid_q, pend_valid_d;
  logic            pend_kind_q, pend_kind_d;
  logic [XLEN-1:0] pend_addr_q, pend_addr_d;

  // A held execute-side redirect outranks a fresh JAL: the older branch
  // resolved in execute is the one that is architecturally correct.
  logic pend_jalr;
  logic pend_jal;
  assign pend_jalr = pend_valid_q && (pend_kind_q == KIND_JALR);
  assign pend_jal  = pend_valid_q && (pend_kind_q == KIND_JAL);

  always_comb begin
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_kind_d  = pend_kind_q;
    pend_addr_d  = pend_addr_q;

    if (rlast) begin
      // Target selection uses if/else so an X on an unselected address bus
      // can never leak into the PC.
      if (jalr_jcond) begin
        pc_d = jalr_jcond_addr;
      end else if (pend_jalr) begin
        pc_d = pend_addr_q;
      end else if (jal) begin
        pc_d = jal_addr;
      end else if (pend_jal) begin
        pc_d = pend_addr_q;
      end else begin
        pc_d = pc_q + XLEN'(PC_STEP);  // wraps modulo 2^XLEN
      end
      pend_valid_d = 1'b0;
    end else begin
      if (jalr_jcond) begin
        pend_valid_d = 1'b1;
        pend_kind_d  = KIND_JALR;
        pend_addr_d  = jalr_jcond_addr;
      end else if (jal && !pend_jalr) begin
        // A JAL never displaces a held JALR, but a newer JAL replaces an older one.
        pend_valid_d = 1'b1;
        pend_kind_d  = KIND_JAL;
        pend_addr_d  = jal_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      pc_q         <= RESET_ADDR;
      pend_valid_q <= 1'b0;
      pend_kind_q  <= KIND_JAL;
      pend_addr_q  <= '0;
    end else begin
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_kind_q  <= pend_kind_d;
      pend_addr_q  <= pend_addr_d;
    end
  end

  assign pc_addr = pc_q;

endmodule

// File: tb/tb_pc_control_unit.sv
// Directed bench for pc_control_unit with hand-computed expected PCs.
module tb_pc_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jal;
  logic        jalr_jcond;
  logic [31:0] jal_addr;
  logic [31:0] jalr_jcond_addr;
  logic        rlast;
  logic [31:0] pc_addr;

  int checks = 0;
  int errors = 0;

  pc_control_unit #(
    .XLEN      (32),
    .RESET_ADDR(32'h0000_0000),
    .PC_STEP   (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .jal            (jal),
    .jalr_jcond     (jalr_jcond),
    .jal_addr       (jal_addr),
    .jalr_jcond_addr(jalr_jcond_addr),
    .rlast          (rlast),
    .pc_addr        (pc_addr)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: pc_addr %h", tag, got);
    end
  endtask

  // Apply inputs, take one rising edge, sample 1 time unit later and compare.
  task automatic cyc(input logic r, input logic rl, input logic j, input logic [31:0] ja,
                     input logic jr, input logic [31:0] jra,
                     input string tag, input logic [31:0] exp);
    rst_n = r; rlast = rl; jal = j; jal_addr = ja; jalr_jcond = jr; jalr_jcond_addr = jra;
    @(posedge clk);
    #1;
    check_val(tag, pc_addr, exp);
  endtask

  initial begin
    rst_n = 1'b1; rlast = 1'b0; jal = 1'b0; jalr_jcond = 1'b0;
    jal_addr = 32'h0; jalr_jcond_addr = 32'h0;
    #2;

    // reset, then sequential fetch
    cyc(1, 0, 0, 32'h0, 0, 32'h0, "reset", 32'h0);
    cyc(0, 1, 0, 32'h0, 0, 32'h0, "seq1", 32'h4);
    cyc(0, 1, 0, 32'h0, 0, 32'h0, "seq2", 32'h8);
    cyc(0, 1, 0, 32'h0, 0, 32'h0, "seq3", 32'hC);

    // JAL held two cycles reloads the same target, then sequential
    cyc(0, 1, 1, 32'd10, 0, 32'h0, "jal1", 32'd10);
    cyc(0, 1, 1, 32'd10, 0, 32'h0, "jal2", 32'd10);
    cyc(0, 1, 0, 32'h0, 0, 32'h0, "jal_seq", 32'd14);

    // jalr beats jal in same cycle; held jalr stays put
    cyc(0, 1, 1, 32'd10, 1, 32'd20, "prio", 32'd20);
    cyc(0, 1, 0, 32'h0, 1, 32'd20, "jalr_held", 32'd20);

    // stall holds pc
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 32'h0, 0, 32'h0, "stall", 32'd20);
    cyc(0, 1, 0, 32'h0, 0, 32'h0, "stall_adv", 32'd24);

    // pending jal overwritten by pending jalr
    cyc(0, 0, 1, 32'h100, 0, 32'h0, "pend_jal", 32'd24);
    cyc(0, 0, 0, 32'h0, 1, 32'h200, "pend_jalr", 32'd24);
    cyc(0, 1, 0, 32'h0, 0, 32'h0, "pend_apply", 32'h200);
    cyc(0, 1, 0, 32'h0, 0, 32'h0, "pend_clear", 32'h204);

    // pending jalr is not displaced by a later stalled jal, and beats a jal at advance
    cyc(0, 0, 0, 32'h0, 1, 32'h300, "pjr_cap", 32'h204);
    cyc(0, 0, 1, 32'h400, 0, 32'h0, "pjr_keep", 32'h204);
    cyc(0, 1, 1, 32'h500, 0, 32'h0, "pjr_vs_jal", 32'h300);
    cyc(0, 1, 0, 32'h0, 0, 32'h0, "pjr_clear", 32'h304);

    // live jal at advance beats pending jal; live jalr beats pending jalr
    cyc(0, 0, 1, 32'h600, 0, 32'h0, "pj_cap", 32'h304);
    cyc(0, 1, 1, 32'h700, 0, 32'h0, "jal_vs_pj", 32'h700);
    cyc(0, 1, 0, 32'h0, 0, 32'h0, "pj_clear", 32'h704);
    cyc(0, 0, 0, 32'h0, 1, 32'h800, "pjr2_cap", 32'h704);
    cyc(0, 1, 0, 32'h0, 1, 32'h900, "jalr_vs_pjr", 32'h900);

    // unaligned target loaded verbatim
    cyc(0, 1, 1, 32'h0000_0013, 0, 32'h0, "unaligned", 32'h0000_0013);

    // reset mid-operation discards pending and overrides requests
    cyc(0, 1, 1, 32'h40, 0, 32'h0, "to_40", 32'h40);
    cyc(0, 0, 1, 32'h80, 0, 32'h0, "pend_80", 32'h40);
    cyc(1, 1, 1, 32'h123, 1, 32'h999, "mid_reset", 32'h0);
    cyc(0, 1, 0, 32'h0, 0, 32'h0, "post_reset", 32'h4);

    // wrap-around
    cyc(0, 1, 0, 32'h0, 1, 32'hFFFF_FFFC, "to_top", 32'hFFFF_FFFC);
    cyc(0, 1, 0, 32'h0, 0, 32'h0, "wrap", 32'h0);

    // unselected address buses carry junk, must not matter
    cyc(0, 1, 0, 32'hDEAD_BEEF, 0, 32'hCAFE_F00D, "ignore_addr", 32'h4);
    cyc(0, 0, 0, 32'hDEAD_BEEF, 0, 32'hCAFE_F00D, "ignore_stall", 32'h4);
    cyc(0, 1, 0, 32'h0, 0, 32'h0, "ignore_adv", 32'h8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
